// File: rtl/approx_mag_pkg.sv
// Shared definitions for the alpha-max-plus-beta-min magnitude pipeline.
package approx_mag_pkg;

    typedef enum logic [1:0] {
        MODE_1_HALF      = 2'b00,
        MODE_7_8_HALF    = 2'b01,
        MODE_15_16_15_32 = 2'b10,
        MODE_1_QUARTER   = 2'b11
    } mag_mode_e;

    localparam int MAG_LAT = 5;

endpackage

// File: rtl/mag_abs_sat.sv
// Saturating absolute value: the most-negative code maps to the largest positive code.
module mag_abs_sat #(
    parameter int DW = 28
) (
    input  logic signed [DW-1:0] x_i,
    output logic        [DW-1:0] abs_o
);

    logic [DW-1:0] neg;

    assign neg = DW'(-x_i);

    always_comb begin
        abs_o = x_i;
        if (x_i == {1'b1, {(DW-1){1'b0}}}) begin
            abs_o = {1'b0, {(DW-1){1'b1}}};
        end else if (x_i[DW-1]) begin
            abs_o = neg;
        end
    end

endmodule

// File: rtl/approx_mag_pipe.sv
// Five-stage alpha-max-plus-beta-min magnitude estimator for signed I/Q samples.
// Optional windowed peak detector is built only when MAG_PEAK_HOLD_EN is defined.
module approx_mag_pipe
    import approx_mag_pkg::*;
#(
    parameter int DW      = 28,
    parameter int WIN_LEN = 1024,
    parameter int CW      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] din_i,
    input  logic signed [DW-1:0] din_q,
    input  logic [1:0]           mode,
    output logic                 dout_valid,
    output logic [DW:0]          dout_mag,
    output logic                 peak_valid,
    output logic [DW:0]          peak_mag
);

    if (DW < 8 || WIN_LEN < 2 || CW < $clog2(WIN_LEN)) begin : g_cfg_check
        $error("approx_mag_pipe: invalid DW/WIN_LEN/CW configuration");
    end

    logic [DW-1:0] abs_i, abs_q;
    logic          v1_q, v2_q, v3_q, v4_q, dout_valid_q;
    logic [DW-1:0] ai1_q, aq1_q, mx2_q, mn2_q, a3_q, b3_q, mx3_q, mx4_q;
    mag_mode_e     m1_q, m2_q;
    logic [DW:0]   s4_q, dout_mag_q;
    logic [DW-1:0] a3_d, b3_d;
    logic [DW:0]   dout_mag_d;

    mag_abs_sat #(.DW(DW)) u_abs_i (.x_i(din_i), .abs_o(abs_i));
    mag_abs_sat #(.DW(DW)) u_abs_q (.x_i(din_q), .abs_o(abs_q));

    always_comb begin
        a3_d = mx2_q;
        b3_d = mn2_q >> 1;
        unique case (m2_q)
            MODE_1_HALF: ;
            MODE_7_8_HALF:    a3_d = mx2_q - (mx2_q >> 3);
            MODE_15_16_15_32: begin
                a3_d = mx2_q - (mx2_q >> 4);
                b3_d = (mn2_q >> 1) - (mn2_q >> 5);
            end
            MODE_1_QUARTER:   b3_d = mn2_q >> 2;
            default: ;
        endcase
    end

    // The max floor keeps the estimate from undershooting when min is small.
    always_comb begin
        dout_mag_d = '0;
        if (v4_q) begin
            dout_mag_d = (s4_q > {1'b0, mx4_q}) ? s4_q : {1'b0, mx4_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
            v4_q         <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_mag_q   <= '0;
        end else begin
            v1_q         <= din_valid;
            v2_q         <= v1_q;
            v3_q         <= v2_q;
            v4_q         <= v3_q;
            dout_valid_q <= v4_q;
            dout_mag_q   <= dout_mag_d;
        end
    end

    always_ff @(posedge clk) begin
        ai1_q <= abs_i;
        aq1_q <= abs_q;
        m1_q  <= mag_mode_e'(mode);
        mx2_q <= (ai1_q >= aq1_q) ? ai1_q : aq1_q;
        mn2_q <= (ai1_q >= aq1_q) ? aq1_q : ai1_q;
        m2_q  <= m1_q;
        a3_q  <= a3_d;
        b3_q  <= b3_d;
        mx3_q <= mx2_q;
        s4_q  <= {1'b0, a3_q} + {1'b0, b3_q};
        mx4_q <= mx3_q;
    end

    assign dout_valid = dout_valid_q;
    assign dout_mag   = dout_mag_q;

`ifdef MAG_PEAK_HOLD_EN
    logic [CW-1:0] win_cnt_q;
    logic [DW:0]   run_q, peak_q, run_max;
    logic          peak_valid_q;

    assign run_max = (dout_mag_q > run_q) ? dout_mag_q : run_q;

    // Down-counter reaches zero on the last sample of each window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt_q    <= CW'(WIN_LEN - 1);
            run_q        <= '0;
            peak_q       <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            peak_valid_q <= 1'b0;
            if (dout_valid_q) begin
                if (win_cnt_q == '0) begin
                    peak_q       <= run_max;
                    peak_valid_q <= 1'b1;
                    win_cnt_q    <= CW'(WIN_LEN - 1);
                    run_q        <= '0;
                end else begin
                    win_cnt_q <= win_cnt_q - 1'b1;
                    run_q     <= run_max;
                end
            end
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_mag   = peak_q;
`else
    assign peak_valid = 1'b0;
    assign peak_mag   = '0;
`endif

endmodule

// File: tb/tb_approx_mag_pipe.sv
// Self-checking bench for approx_mag_pipe; define MAG_PEAK_HOLD_EN to exercise the peak detector.
module tb_approx_mag_pipe;

    localparam int DW     = 28;
    localparam int TB_WIN = 4;
    localparam int LAT    = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 din_valid;
    logic signed [DW-1:0] din_i, din_q;
    logic [1:0]           mode;
    logic                 dout_valid;
    logic [DW:0]          dout_mag;
    logic                 peak_valid;
    logic [DW:0]          peak_mag;

    int n_tests = 0;
    int n_fail  = 0;

    longint mag_log[$];
    bit     v_log[$];
    longint pk_log[$];

    bit     exp_v[LAT];
    longint exp_m[LAT];
    bit     exp_pv;
    longint exp_pm;
    int     win_n;
    longint win_max;

    always #5 clk = ~clk;

    approx_mag_pipe #(.DW(DW), .WIN_LEN(TB_WIN), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
        .mode(mode), .dout_valid(dout_valid), .dout_mag(dout_mag),
        .peak_valid(peak_valid), .peak_mag(peak_mag)
    );

    function automatic longint model_mag(longint i, longint q, int m);
        longint lim, ai, aq, mx, mn, s;
        lim = (longint'(1) <<< (DW - 1)) - 1;
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        if (ai > lim) ai = lim;
        if (aq > lim) aq = lim;
        mx = (ai >= aq) ? ai : aq;
        mn = (ai >= aq) ? aq : ai;
        case (m)
            0:       s = mx + mn / 2;
            1:       s = mx - mx / 8 + mn / 2;
            2:       s = mx - mx / 16 + mn / 2 - mn / 32;
            default: s = mx + mn / 4;
        endcase
        return (s > mx) ? s : mx;
    endfunction

    task automatic chk(string name, longint got, longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Reference: magnitude computed per sample, carried through a latency-deep delay line.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                exp_v[k] = 1'b0;
                exp_m[k] = 0;
            end
            exp_pv = 1'b0; exp_pm = 0; win_n = 0; win_max = 0;
        end else begin
`ifdef MAG_PEAK_HOLD_EN
            exp_pv = 1'b0;
            if (exp_v[LAT-1]) begin
                win_n++;
                if (exp_m[LAT-1] > win_max) win_max = exp_m[LAT-1];
                if (win_n == TB_WIN) begin
                    exp_pm = win_max; exp_pv = 1'b1; win_n = 0; win_max = 0;
                end
            end
`endif
            for (int k = LAT - 1; k > 0; k--) begin
                exp_v[k] = exp_v[k-1];
                exp_m[k] = exp_m[k-1];
            end
            exp_v[0] = din_valid;
            exp_m[0] = din_valid ? model_mag(longint'(din_i), longint'(din_q), int'(mode)) : 0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("dout_valid", longint'(dout_valid), longint'(exp_v[LAT-1]));
        chk("dout_mag", longint'(dout_mag), exp_m[LAT-1]);
        chk("peak_valid", longint'(peak_valid), longint'(exp_pv));
        chk("peak_mag", longint'(peak_mag), exp_pm);
        v_log.push_back(dout_valid);
        if (dout_valid) mag_log.push_back(longint'(dout_mag));
        if (peak_valid) pk_log.push_back(longint'(peak_mag));
    end

    task automatic drive(bit v, longint i, longint q, int m);
        @(negedge clk);
        din_valid = v;
        din_i     = DW'(i);
        din_q     = DW'(q);
        mode      = 2'(m);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0);
    endtask

    task automatic clear_logs();
        mag_log.delete();
        v_log.delete();
        pk_log.delete();
    endtask

    function automatic longint qget(int idx);
        return (idx < mag_log.size()) ? mag_log[idx] : -1;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        longint e1[4] = '{5500, 5000, 5157, 4750};
        bit     gap_v[10] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0};
        logic [DW-1:0] r_i, r_q;

        rst_n = 1'b0; din_valid = 1'b0; din_i = '0; din_q = '0; mode = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_dout_valid", longint'(dout_valid), 0);
        chk("reset_dout_mag", longint'(dout_mag), 0);
        chk("reset_peak_valid", longint'(peak_valid), 0);
        chk("reset_peak_mag", longint'(peak_mag), 0);

        clear_logs();
        for (int m = 0; m < 4; m++) drive(1'b1, 3000, 4000, m);
        idle(7);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("modes_mag%0d", k), qget(k), e1[k]);
            chk($sformatf("modes_valid_at%0d", k + LAT), longint'(v_log[k + LAT]), 1);
        end
        chk("modes_first_not_early", longint'(v_log[LAT-1]), 0);

        clear_logs();
        drive(1'b1, -(longint'(1) <<< (DW - 1)), 0, 1);
        idle(7);
        chk("sat_mag", qget(0), 134217727);

        clear_logs();
        drive(1'b1, -5, 5, 0);
        drive(1'b1, 0, 0, 0);
        idle(7);
        chk("tie_mag", qget(0), 7);
        chk("zero_mag", qget(1), 0);
        chk("tie_zero_count", longint'(mag_log.size()), 2);

        clear_logs();
        drive(1'b1, 100, 0, 0);
        drive(1'b0, 999, 999, 0);
        drive(1'b1, 3, 4, 1);
        drive(1'b1, -7, 2, 3);
        drive(1'b0, 555, -555, 2);
        idle(5);
        for (int k = 0; k < 10; k++)
            chk($sformatf("gap_valid%0d", k), longint'(v_log[k]), longint'(gap_v[k]));
        chk("gap_count", longint'(mag_log.size()), 3);

        clear_logs();
        drive(1'b1, 50, 60, 2);
        drive(1'b1, -70, 80, 1);
        drive(1'b1, 90, -10, 3);
        pulse_reset();
        chk("rst_dout_valid", longint'(dout_valid), 0);
        chk("rst_dout_mag", longint'(dout_mag), 0);
        chk("rst_peak_valid", longint'(peak_valid), 0);
        chk("rst_peak_mag", longint'(peak_mag), 0);
        idle(7);
        chk("rst_discard_count", longint'(mag_log.size()), 0);
        drive(1'b1, 3000, 4000, 0);
        idle(7);
        chk("post_rst_mag", qget(0), 5500);

        for (int k = 0; k < 40; k++) begin
            r_i = DW'($urandom);
            r_q = DW'($urandom);
            if (k % 9 == 0) r_i = {1'b1, {(DW-1){1'b0}}};
            drive(1'($urandom_range(0, 1)), longint'($signed(r_i)), longint'($signed(r_q)),
                  int'($urandom_range(0, 3)));
        end
        idle(7);

        pulse_reset();
        clear_logs();
        drive(1'b1, 10, 0, 0);
        drive(1'b1, 90, 0, 0);
        drive(1'b1, 30, 0, 0);
        drive(1'b1, 20, 0, 0);
        drive(1'b1, 5, 0, 0);
        drive(1'b1, 6, 0, 0);
        drive(1'b1, 7, 0, 0);
        drive(1'b1, 8, 0, 0);
        idle(8);
`ifdef MAG_PEAK_HOLD_EN
        chk("peak_count", longint'(pk_log.size()), 2);
        chk("peak_first", (pk_log.size() > 0) ? pk_log[0] : -1, 90);
        chk("peak_second", (pk_log.size() > 1) ? pk_log[1] : -1, 8);
        chk("peak_hold", longint'(peak_mag), 8);
`else
        chk("peak_off_count", longint'(pk_log.size()), 0);
        chk("peak_off_mag", longint'(peak_mag), 0);
`endif
        chk("window_mag_count", longint'(mag_log.size()), 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_mag_pipe.md
Name: approx_mag_pipe

Overview:
Parametrised, fully pipelined alpha-max-plus-beta-min magnitude estimator for signed I/Q sample streams. It generalises the team's fixed 28-bit, 7/8-1/2 magnitude block with configurable width, a per-sample coefficient mode, a valid-qualified pipeline, synchronous reset and an optional windowed peak detector. It sits after the channel filter / correlator and feeds detection thresholds and AGC.

Parameters:
DW, 28, input sample width (signed two's complement), min 8
WIN_LEN, 1024, peak-hold window length in valid samples (used only with MAG_PEAK_HOLD_EN), min 2
CW, 16, width of the window counter; requires 2^CW >= WIN_LEN

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst_n  in  1  synchronous, active-low reset
din_valid  in  1  input sample qualifier
din_i  in  DW  signed I sample
din_q  in  DW  signed Q sample
mode  in  2  coefficient set, sampled when din_valid=1
dout_valid  out  1  output qualifier
dout_mag  out  DW+1  unsigned magnitude estimate
peak_valid  out  1  one-cycle pulse at window end (tied 0 when the feature is off)
peak_mag  out  DW+1  window peak (tied 0 when the feature is off)

Behaviour:
- Interface: one clock; reset is synchronous and active-low, sampled on the clk rising edge while rst_n=0.
- Reset: dout_valid=0, dout_mag=0, peak_valid=0, peak_mag=0. All valid-pipeline bits are cleared. Data registers may stay uncleared.
- Fixed latency is 5 cycles from din_valid to dout_valid. Throughput is one sample per cycle with no back-pressure. Gaps in din_valid are preserved exactly.
- Stage 1: absolute value. The most-negative input -2^(DW-1) saturates to 2^(DW-1)-1. The mode is registered alongside the data and travels with it.
- Stage 2: max = larger of |I| and |Q|, min = the other. If they are equal, max = |I|.
- Stage 3: per-sample mode terms, computed with truncating right shifts.
  - mode 00: a = max, b = min>>1
  - mode 01: a = max-(max>>3), b = min>>1
  - mode 10: a = max-(max>>4), b = (min>>1)-(min>>5)
  - mode 11: a = max, b = min>>2
- Stage 4: s = a+b, computed in DW+1 bits with no overflow.
- Stage 5: dout_mag = larger of s and zero-extended max. This refinement applies in every mode.
- When dout_valid=0, dout_mag is forced to 0.
- Mode changes between consecutive valid samples take effect per sample. There are no bubbles and no cross-contamination between samples.
- Reset while samples are in flight discards them. dout_valid stays 0 until 5 cycles after the first post-reset din_valid.

Optional Feature:
MAG_PEAK_HOLD_EN
- Defined:
  - Tracks the maximum dout_mag over each window of WIN_LEN valid outputs, using a counter of width CW.
  - On the WIN_LEN-th valid output, peak_mag is set to the max of the running peak and that final sample, and peak_valid pulses for 1 cycle, in the cycle after that dout_valid.
  - The running peak and counter restart with the next sample. Back-to-back windows have no gap sample.
  - Reset mid-window discards the partial window.
  - peak_mag holds its value between pulses.
- Undefined: no counter or peak logic is built; peak_valid=0 and peak_mag=0 constantly.

Decomposition:
- Package approx_mag_pkg holds:
  - mode encodings: MODE_1_HALF=2'b00, MODE_7_8_HALF=2'b01, MODE_15_16_15_32=2'b10, MODE_1_QUARTER=2'b11
  - pipeline latency constant MAG_LAT=5
- One sub-module, mag_abs_sat, performs the stage-1 saturating absolute value and is instantiated once for I and once for Q.
- The peak tracker stays inline, under the macro.

Test Plan:
- DW=28, I=3000, Q=4000 with mode 00/01/10/11 in 4 consecutive cycles -> dout_mag 5500, 5000, 5157, 4750 in 4 consecutive cycles, starting 5 cycles after the first input.
- I=-2^27, Q=0, mode 01 -> |I| saturates to 134217727; s=117440512; dout_mag=134217727.
- I=-5, Q=5, mode 00 (tie) -> max=5, min=5; dout_mag=7. Also I=0, Q=0 -> dout_mag=0 with dout_valid=1.
- din_valid pattern 1,0,1,1,0 -> dout_valid reproduces the same pattern delayed by 5 cycles; dout_mag=0 in the gap cycles.
- rst_n=0 for 1 cycle while 3 samples are in flight -> no dout_valid for those samples; all outputs are 0 the next cycle.
- MAG_PEAK_HOLD_EN, WIN_LEN=4, magnitudes 10, 90, 30, 20, 5, 6, 7, 8 -> peak_valid pulses twice, with peak_mag 90 then 8, one cycle after the 4th and 8th dout_valid.
